// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per request, with byte-lane
// alignment of store data and sign/zero extension of load data.
module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fault_o,
  output logic [31:0]       rdata_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ready_i,
  input  logic [31:0]       dmem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic [1:0]  off_s;
  logic        fault_s;
  logic        accept_s;
  logic        load_done_s;

  function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (f3[1:0])
      2'b00:   lanes = {4{wdata[7:0]}};
      2'b01:   lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b010:  res = word;
      3'b100:  res = {24'h000000, sh[7:0]};
      3'b101:  res = {16'h0000, sh[15:0]};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Unsigned loads are illegal as stores; everything else checks natural alignment.
  function automatic logic check_fault(input logic [2:0] f3, input logic [1:0] off,
                                       input logic is_write);
    logic flt;
    case (f3)
      3'b000:  flt = 1'b0;
      3'b001:  flt = off[0];
      3'b010:  flt = (off != 2'b00);
      3'b100:  flt = is_write;
      3'b101:  flt = is_write | off[0];
      default: flt = 1'b1;
    endcase
    return flt;
  endfunction

  // Next-state logic and transaction bookkeeping strobes.
  always_comb begin
    state_s     = state_r;
    off_s       = addr_i[1:0];
    fault_s     = check_fault(funct3_i, off_s, mem_write_i);
    accept_s    = 1'b0;
    load_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_i && (mem_read_i || mem_write_i)) begin
          if (fault_s) begin
            state_s = FAULT;
          end else begin
            state_s  = REQ;
            accept_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (dmem_ready_i) begin
          state_s     = DONE;
          load_done_s = ~dmem_we_o;
        end else begin
          state_s = REQ;
        end
      end
      DONE:    state_s = IDLE;
      FAULT:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, status outputs and memory-side registers; status outputs mirror the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r      <= IDLE;
      f3_r         <= 3'b000;
      off_r        <= 2'b00;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      fault_o      <= 1'b0;
      rdata_o      <= 32'h0000_0000;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= 4'b0000;
      dmem_wdata_o <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      busy_o     <= (state_s == REQ);
      dmem_req_o <= (state_s == REQ);
      done_o     <= (state_s == DONE) || (state_s == FAULT);
      fault_o    <= (state_s == FAULT);
      if (accept_s) begin
        f3_r         <= funct3_i;
        off_r        <= off_s;
        dmem_we_o    <= mem_write_i;
        dmem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
        dmem_be_o    <= calc_be(funct3_i, off_s);
        dmem_wdata_o <= store_lanes(funct3_i, wdata_i);
      end
      if (load_done_s) begin
        rdata_o <= load_extract(f3_r, off_r, dmem_rdata_i);
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected results, a monitor
// compares them whenever the DUT raises dmem_req_o or done_o.
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, fault_o;
  logic [31:0] rdata_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ready_i;
  logic [31:0] dmem_rdata_i;

  lsu #(.ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o), .rdata_o(rdata_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ready_i(dmem_ready_i),
    .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          fault;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          busy;
    int          done_cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          abort = 1'b1;
  logic [31:0] last_rd = 32'h0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_done"}, {31'd0, done_o}, 32'd0);
    check({tag, "_fault"}, {31'd0, fault_o}, 32'd0);
    check({tag, "_rdata"}, rdata_o, 32'd0);
    check({tag, "_req"}, {31'd0, dmem_req_o}, 32'd0);
    check({tag, "_we"}, {31'd0, dmem_we_o}, 32'd0);
    check({tag, "_addr"}, dmem_addr_o, 32'd0);
    check({tag, "_be"}, {28'd0, dmem_be_o}, 32'd0);
    check({tag, "_wdata"}, dmem_wdata_o, 32'd0);
  endtask

  // Monitor: compares requests and completions against the scoreboard front.
  initial begin
    int  busy_cnt = 0;
    bit  req_seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (abort || !rst_n_i) begin
        busy_cnt = 0;
        req_seen = 1'b0;
      end else begin
        if (busy_o) busy_cnt++;
        if (dmem_req_o) begin
          req_seen = 1'b1;
          if (q.size() == 0) begin
            check("req_unexpected", 32'd1, 32'd0);
          end else begin
            e = q[0];
            check("req_on_fault", {31'd0, e.fault}, 32'd0);
            check("req_we", {31'd0, dmem_we_o}, {31'd0, e.we});
            check("req_addr", dmem_addr_o, e.addr);
            check("req_be", {28'd0, dmem_be_o}, {28'd0, e.be});
            if (e.we) check("req_wdata", dmem_wdata_o, e.wdata);
          end
        end
        if (done_o) begin
          if (q.size() == 0) begin
            check("done_unexpected", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("fault", {31'd0, fault_o}, {31'd0, e.fault});
            check("rdata", rdata_o, e.rdata);
            check("busy_cycles", busy_cnt, e.busy);
            check("req_seen", {31'd0, req_seen}, {31'd0, ~e.fault});
          end
          busy_cnt = 0;
          req_seen = 1'b0;
        end
      end
    end
  end

  // Reference model: expected outcome of one access from the architectural rules.
  function automatic exp_t model(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rword, input int waits);
    exp_t e;
    int unsigned size, o, v;
    bit legal;
    legal = (f3 <= 3'd2) || (((f3 == 3'd4) || (f3 == 3'd5)) && !wr);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    o     = addr % 4;
    e.fault = !legal || ((addr % size) != 0);
    e.we    = wr;
    e.addr  = addr - o;
    e.be    = 4'(((1 << size) - 1) << o);
    e.wdata = (size == 1) ? wdata[7:0] * 32'h0101_0101 :
              (size == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
    v = rword >> (8 * o);
    if (size == 1) begin
      v = v % 256;
      if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2) begin
      v = v % 65536;
      if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rword;
    end
    if (!e.fault && !wr) last_rd = v;
    e.rdata = last_rd;
    e.busy  = e.fault ? 0 : waits + 1;
    return e;
  endfunction

  // One access, entered and left at a negedge in IDLE.
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rword, input int waits,
                       input bit pulse);
    exp_t e;
    e = model(wr, f3, addr, wdata, rword, waits);
    e.done_cyc = cyc + (e.fault ? 1 : waits + 2);
    q.push_back(e);
    start_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
    funct3_i = f3; addr_i = addr; wdata_i = wdata;
    @(negedge clk_i);
    start_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    addr_i = $urandom; wdata_i = $urandom;
    if (!e.fault) begin
      for (int k = 0; k < waits; k++) begin
        dmem_ready_i = 1'b0;
        dmem_rdata_i = $urandom;
        if (pulse && k == 0) begin
          start_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b1; funct3_i = 3'd2;
        end
        @(negedge clk_i);
        start_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
      end
      dmem_ready_i = 1'b1;
      dmem_rdata_i = rword;
      @(negedge clk_i);
      dmem_ready_i = 1'b0;
      dmem_rdata_i = $urandom;
    end
    dmem_ready_i = $urandom_range(0, 1);
    @(negedge clk_i);
    dmem_ready_i = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind;
    rst_n_i = 1'b0; start_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    funct3_i = 3'd0; addr_i = 32'h0; wdata_i = 32'h0;
    dmem_ready_i = 1'b0; dmem_rdata_i = 32'h0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_n_i = 1'b1;
    @(negedge clk_i);
    abort = 1'b0;

    do_op(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    do_op(1'b0, 1'b1, 3'd0, 32'h103, 32'h12345678, 32'h0, 1, 1'b0);
    do_op(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF7F01, 0, 1'b0);
    do_op(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF7F01, 0, 1'b0);
    do_op(1'b1, 1'b0, 3'd1, 32'h202, 32'h0, 32'h8001ABCD, 0, 1'b0);
    do_op(1'b1, 1'b0, 3'd5, 32'h202, 32'h0, 32'h8001ABCD, 2, 1'b0);
    do_op(1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 32'h8001ABCD, 3, 1'b0);
    do_op(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1'b0);
    do_op(1'b0, 1'b1, 3'd1, 32'h203, 32'h5555, 32'h0, 0, 1'b0);
    do_op(1'b1, 1'b0, 3'd3, 32'h200, 32'h0, 32'h0, 0, 1'b0);
    do_op(1'b0, 1'b1, 3'd4, 32'h200, 32'h0, 32'h0, 0, 1'b0);
    do_op(1'b1, 1'b0, 3'd0, 32'h301, 32'h0, 32'h0000_7F00, 2, 1'b1);
    do_op(1'b1, 1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 32'h1111_1111, 1, 1'b0);

    // Start with neither read nor write must produce no transaction.
    start_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h40;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset during the second REQ cycle with ready asserted abandons the access.
    abort = 1'b1;
    start_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h400;
    @(negedge clk_i);
    start_i = 1'b0; mem_read_i = 1'b0;
    check("midreq_req", {31'd0, dmem_req_o}, 32'd1);
    @(negedge clk_i);
    rst_n_i = 1'b0; dmem_ready_i = 1'b1; dmem_rdata_i = 32'hA5A5_A5A5;
    @(negedge clk_i);
    check_all_zero("midreq_rst");
    rst_n_i = 1'b1; dmem_ready_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_done", {31'd0, done_o}, 32'd0);
    check("post_rst_req", {31'd0, dmem_req_o}, 32'd0);
    last_rd = 32'h0;
    abort = 1'b0;
    do_op(1'b0, 1'b1, 3'd1, 32'h402, 32'h0000_BEEF, 32'h0, 0, 1'b0);
    do_op(1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 32'h1234_5678, 1, 1'b0);

    for (int i = 0; i < 80; i++) begin
      f3   = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 2);
      a    = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      do_op(kind != 1, kind != 0, f3, a, $urandom, $urandom, $urandom_range(0, 3),
            $urandom_range(0, 3) == 0);
    end

    repeat (4) @(negedge clk_i);
    check("scoreboard_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the ALU in the execute path. It takes the ALU result as the effective address, plus the store data and funct3, and runs one data-memory transaction over a request/ready handshake. It aligns store data into byte lanes and extracts and extends load data. While a transaction is in flight it holds `busy_o` high so the core can stall.

## Interface
- `ADDR_W`, 32, address width; data path fixed at 32 bits
- `clk_i` input 1: clock, rising edge
- `rst_n_i` input 1: synchronous, active-low reset
- `start_i` input 1: request strobe from core; sampled only in IDLE
- `mem_read_i` input 1: load request
- `mem_write_i` input 1: store request; wins over `mem_read_i` if both set
- `funct3_i` input 3: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only)
- `addr_i` input ADDR_W: effective address from the ALU result
- `wdata_i` input 32: store data (rs2)
- `busy_o` output 1: high from the accepting edge until the cycle before `done_o`
- `done_o` output 1: one-cycle completion pulse
- `fault_o` output 1: one-cycle pulse, coincident with `done_o`, on misaligned access or illegal funct3
- `rdata_o` output 32: extended load result
- `dmem_req_o` output 1: memory request
- `dmem_we_o` output 1: 1 = write
- `dmem_addr_o` output ADDR_W: word-aligned address, `{addr[ADDR_W-1:2],2'b00}`
- `dmem_be_o` output 4: byte enables
- `dmem_wdata_o` output 32: lane-replicated store data
- `dmem_ready_i` input 1: memory accepts and completes the request this cycle
- `dmem_rdata_i` input 32: read word, valid when `dmem_ready_i`=1 and it is a read

## Operation
- FSM states: IDLE, REQ, DONE, FAULT.
- IDLE:
  - `start_i`=1 with read or write set: check alignment.
    - H/HU require addr[0]=0.
    - W requires addr[1:0]=00.
    - Illegal funct3 (011, 110, 111, or a store with 100/101) counts as a fault.
  - On a fault: go to FAULT. No memory request is issued.
  - Otherwise: register the address, we, be and wdata, and go to REQ.
  - `start_i` with neither read nor write set is ignored.
- REQ: `dmem_req_o`=1. All `dmem_*` outputs stay stable until `dmem_ready_i`=1. On ready:
  - For a load, capture the extracted lane.
  - Go to DONE.
- DONE: `done_o`=1. For a load, `rdata_o` is updated on entry to this state. Next state is IDLE.
- FAULT: `done_o`=1 and `fault_o`=1. `rdata_o` is unchanged. Next state is IDLE.
- Byte enables, with `o` = addr[1:0]:
  - B/BU: `4'b0001<<o`
  - H/HU: `4'b0011<<o`
  - W: `4'b1111`
  - Loads drive the same `be` as stores.
- Store data:
  - SB: `{4{wdata[7:0]}}`
  - SH: `{2{wdata[15:0]}}`
  - SW: `wdata`
- Load extraction:
  - Byte = `rdata >> (8*o)` [7:0]. Half = `rdata >> (8*o)` [15:0].
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes the word through.
- `rdata_o` holds its value until the next load completes. Stores and faults do not change it.
- `start_i` outside IDLE is ignored; it is neither queued nor counted.
- Reset (`rst_n_i`=0 at an edge):
  - All outputs go to 0 after that edge, including `rdata_o` and `dmem_*`.
  - State goes to IDLE.
  - Reset mid-REQ abandons the transaction: `dmem_req_o` drops after the reset edge, and a `dmem_ready_i` in the same cycle is ignored.

## Timing
- Start accepted at edge N → `dmem_req_o` high in cycle N+1, `busy_o` high from N+1.
- Ready seen at edge M → DONE state during cycle M+1: `done_o`=1, `busy_o`=0, and `rdata_o` valid for a load.
- Minimum latency is 2 cycles (ready already high in the first REQ cycle).
- Each extra wait cycle on `dmem_ready_i` adds one cycle of latency.
- Faults: `done_o`/`fault_o` in cycle N+1, and `dmem_req_o` never asserts.
- Back-to-back: a new `start_i` can be accepted in the cycle after DONE (IDLE). Throughput is at most one access per 3 cycles.
- `dmem_ready_i` outside REQ is ignored.
- No combinational path from any input to any output; every output comes straight from a register.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, ready immediately → req with we=1, addr 0x100, be=1111, wdata 0xDEADBEEF. `done_o` 2 cycles after start; `rdata_o` unchanged.
- SB addr 0x103, wdata 0x12345678 → be=1000, wdata 0x78787878. LB addr 0x103 with dmem_rdata 0x80FF7F01 → `rdata_o`=0xFFFFFF80. LBU at the same address → 0x00000080.
- LH addr 0x202 with rdata 0x8001ABCD → 0xFFFF8001. LHU → 0x00008001. LW with 3 wait cycles → `busy_o` high for 4 cycles, then `done_o` with 0x8001ABCD.
- LW addr 0x101, then SH addr 0x203, then funct3=011 → each gives `done_o`+`fault_o` one cycle after start, `dmem_req_o` stays 0, `rdata_o` unchanged.
- `start_i` pulsed during REQ → ignored, exactly one `done_o`. Read+write both set → a store is issued.
- Reset asserted in the second REQ cycle, with ready in the same cycle → after the edge all outputs are 0 and the FSM is in IDLE, with no `done_o`. A new LW completes normally afterwards.
